// File: rtl/servo_pkg.sv
// Shared defaults, counter width and command clamp for the servo PWM generator.
package servo_pkg;

  localparam int unsigned DEF_TICKS_PER_US = 100;
  localparam int unsigned DEF_PERIOD_US    = 20000;
  localparam int unsigned DEF_MIN_US       = 500;
  localparam int unsigned DEF_MAX_US       = 2500;
  localparam int unsigned DEF_SLEW_US      = 20;
  localparam int unsigned US_CNT_W         = $clog2(DEF_PERIOD_US);

  // Zero stays zero (channel off); any other width is forced into [lo, hi].
  function automatic int unsigned clamp_us(input int unsigned x,
                                           input int unsigned lo,
                                           input int unsigned hi);
    if (x == 0)       return 0;
    else if (x < lo)  return lo;
    else if (x > hi)  return hi;
    else              return x;
  endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Command/status bundle between the steering logic and servo_pwm_multi.
interface servo_pwm_multi_if #(
  parameter int unsigned N_CH = 2,
  parameter int unsigned W    = 12
);
  logic              en;
  logic [N_CH*W-1:0] cmd_us;
  logic              cmd_we;
  logic [N_CH-1:0]   pwm;
  logic              frame_start;
  logic              update_pending;

  modport master (output en, cmd_us, cmd_we,
                  input  pwm, frame_start, update_pending);
  modport slave  (input  en, cmd_us, cmd_we,
                  output pwm, frame_start, update_pending);
endinterface

// File: rtl/servo_frame_timer.sv
// Microsecond prescaler and frame counter; boundary marks the last tick of a frame.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned TICKS_PER_US = DEF_TICKS_PER_US,
  parameter int unsigned PERIOD_US    = DEF_PERIOD_US,
  parameter int unsigned CNT_W        = US_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick,
  output logic [CNT_W-1:0] us_cnt,
  output logic             boundary
);
  localparam int unsigned PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  logic [PRE_W-1:0] prescaler;

  assign tick     = (prescaler == PRE_W'(TICKS_PER_US - 1));
  assign boundary = tick && (us_cnt == CNT_W'(PERIOD_US - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      us_cnt    <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick)
        us_cnt <= boundary ? '0 : us_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel hobby-servo PWM generator; commands are shadowed and applied at frame boundaries.
// Optional macro SERVO_SLEW_EN limits each per-frame width change to SLEW_US.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned W            = 12,
  parameter int unsigned TICKS_PER_US = DEF_TICKS_PER_US,
  parameter int unsigned PERIOD_US    = DEF_PERIOD_US,
  parameter int unsigned MIN_US       = DEF_MIN_US,
  parameter int unsigned MAX_US       = DEF_MAX_US,
  parameter int unsigned SLEW_US      = DEF_SLEW_US
) (
  input logic            clk,
  input logic            rst,
  servo_pwm_multi_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(PERIOD_US);
  localparam int unsigned CMP_W = (W > CNT_W) ? W : CNT_W;

  if (MAX_US >= PERIOD_US || MIN_US > MAX_US || SLEW_US == 0) begin : g_param_check
    $error("servo_pwm_multi: inconsistent timing parameters");
  end

  logic             tick;
  logic             boundary;
  logic             apply;
  logic [CNT_W-1:0] us_cnt;
  logic [N_CH-1:0]  settled;
  logic             frame_q;
  logic             upd_q;

  servo_frame_timer #(
    .TICKS_PER_US (TICKS_PER_US),
    .PERIOD_US    (PERIOD_US),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .us_cnt   (us_cnt),
    .boundary (boundary)
  );

  assign apply = tick & boundary;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W-1:0] pending;
    logic [W-1:0] active;
    logic [W-1:0] target;
    logic [W-1:0] next_active;
    logic         pwm_q;

    assign target = W'(clamp_us(32'(pending), MIN_US, MAX_US));

`ifdef SERVO_SLEW_EN
    localparam logic [W-1:0] STEP = W'(SLEW_US);

    // Switching on from off or switching off bypasses the rate limit.
    always_comb begin
      next_active = target;
      if (active != '0 && target != '0) begin
        if (target > active && (target - active) > STEP)
          next_active = active + STEP;
        else if (active > target && (active - target) > STEP)
          next_active = active - STEP;
      end
    end
`else
    assign next_active = target;
`endif

    assign settled[i] = (next_active == target);

    always_ff @(posedge clk) begin
      if (rst) begin
        pending <= '0;
        active  <= '0;
        pwm_q   <= 1'b0;
      end else begin
        if (bus.cmd_we)
          pending <= bus.cmd_us[i*W +: W];
        if (apply)
          active <= next_active;
        pwm_q <= bus.en & (CMP_W'(us_cnt) < CMP_W'(active));
      end
    end

    assign bus.pwm[i] = pwm_q;
  end

  // A write on the boundary cycle still loads the old pending value, so it must keep the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      frame_q <= apply;
      if (bus.cmd_we)
        upd_q <= 1'b1;
      else if (apply && (&settled))
        upd_q <= 1'b0;
    end
  end

  assign bus.frame_start    = frame_q;
  assign bus.update_pending = upd_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Self-checking bench for servo_pwm_multi against a frame-level reference model.
module tb_servo_pwm_multi;
  localparam int unsigned N_CH    = 2;
  localparam int unsigned W       = 12;
  localparam int unsigned TPU     = 2;
  localparam int unsigned PER     = 100;
  localparam int unsigned MIN_US  = 10;
  localparam int unsigned MAX_US  = 50;
  localparam int unsigned SLEW_US = 5;
  localparam int FRAME_CLK = TPU * PER;

  logic clk = 1'b0;
  logic rst = 1'b1;

  servo_pwm_multi_if #(.N_CH(N_CH), .W(W)) bus ();

  servo_pwm_multi #(
    .N_CH(N_CH), .W(W), .TICKS_PER_US(TPU), .PERIOD_US(PER),
    .MIN_US(MIN_US), .MAX_US(MAX_US), .SLEW_US(SLEW_US)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: frame position from elapsed cycles, widths per the clamp/slew rules.
  int m_cyc;
  int m_pend[N_CH];
  int m_act[N_CH];
  bit m_upd;

  function automatic int ref_clamp(input int x);
    if (x == 0) return 0;
    if (x < int'(MIN_US)) return int'(MIN_US);
    if (x > int'(MAX_US)) return int'(MAX_US);
    return x;
  endfunction

  always @(posedge clk) begin : model
    int t;
    bit bnd;
    bit all_ok;
    if (rst) begin
      m_cyc = 0;
      m_upd = 0;
      foreach (m_act[c]) begin
        m_act[c]  = 0;
        m_pend[c] = 0;
      end
    end else begin
      m_cyc++;
      bnd    = (m_cyc % FRAME_CLK) == 0;
      all_ok = 1;
      if (bnd) begin
        foreach (m_act[c]) begin
          t = ref_clamp(m_pend[c]);
`ifdef SERVO_SLEW_EN
          if (m_act[c] == 0 || t == 0)       m_act[c] = t;
          else if (t > m_act[c] + int'(SLEW_US)) m_act[c] = m_act[c] + int'(SLEW_US);
          else if (t < m_act[c] - int'(SLEW_US)) m_act[c] = m_act[c] - int'(SLEW_US);
          else                                m_act[c] = t;
`else
          m_act[c] = t;
`endif
          if (m_act[c] != t) all_ok = 0;
        end
      end
      if (bus.cmd_we === 1'b1) begin
        foreach (m_pend[c]) m_pend[c] = int'(bus.cmd_us[c*W +: W]);
        m_upd = 1;
      end else if (bnd && all_ok) begin
        m_upd = 0;
      end
    end
  end

  int hi_cnt[N_CH];
  int fs_cnt;
  int exp_hi[N_CH];

  task automatic write_cmd(input int a, input int b);
    bus.cmd_us[0 +: W] = W'(a);
    bus.cmd_us[W +: W] = W'(b);
    bus.cmd_we = 1'b1;
    @(negedge clk);
    bus.cmd_we = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (bus.frame_start !== 1'b1 && n < 3 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    if (bus.frame_start !== 1'b1) begin
      tests++; fails++;
      $display("FAIL wait_frame: frame_start not seen within %0d cycles", 3 * FRAME_CLK);
    end
  endtask

  task automatic snapshot();
    foreach (exp_hi[c]) exp_hi[c] = int'(TPU) * m_act[c];
  endtask

  // Starts on a frame_start sample and ends on the next one.
  task automatic measure_frame();
    fs_cnt = 0;
    foreach (hi_cnt[c]) hi_cnt[c] = 0;
    for (int i = 0; i < FRAME_CLK; i++) begin
      if (bus.frame_start === 1'b1) fs_cnt++;
      for (int c = 0; c < int'(N_CH); c++)
        if (bus.pwm[c] === 1'b1) hi_cnt[c]++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name);
    snapshot();
    measure_frame();
    for (int c = 0; c < int'(N_CH); c++) begin
      tests++;
      if (hi_cnt[c] !== exp_hi[c]) begin
        fails++;
        $display("FAIL %s ch%0d high_clk: got %0d expected %0d", name, c, hi_cnt[c], exp_hi[c]);
      end
    end
    tests++;
    if (fs_cnt !== 1 || bus.frame_start !== 1'b1) begin
      fails++;
      $display("FAIL %s frame_period: pulses=%0d next_start=%b expected 1/1", name, fs_cnt, bus.frame_start);
    end
  endtask

  task automatic settle();
    int k = 0;
    do begin
      @(negedge clk);
      wait_frame();
      k++;
    end while (m_upd && k < 20);
  endtask

  task automatic test_reset();
    int n = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.cmd_we = 1'b0;
    bus.cmd_us = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.pwm, bus.frame_start, bus.update_pending} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: pwm=%b fs=%b upd=%b expected all 0",
               bus.pwm, bus.frame_start, bus.update_pending);
    end
    rst = 1'b0;
    while (bus.frame_start !== 1'b1 && n < 5 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != FRAME_CLK) begin
      fails++;
      $display("FAIL first_frame_start: at clk %0d expected %0d", n, FRAME_CLK);
    end
    for (int f = 0; f < 3; f++) check_frame("idle");
  endtask

  task automatic test_write();
    repeat (50) @(negedge clk);
    write_cmd(30, 40);
    tests++;
    if (bus.update_pending !== 1'b1) begin
      fails++;
      $display("FAIL write_pending: got %b expected 1", bus.update_pending);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (bus.pwm !== '0) begin
      fails++;
      $display("FAIL write_not_early: pwm=%b expected 00", bus.pwm);
    end
    wait_frame();
    tests++;
    if (bus.update_pending !== m_upd) begin
      fails++;
      $display("FAIL write_applied_pending: got %b expected %b", bus.update_pending, m_upd);
    end
    check_frame("write_30_40");
  endtask

  task automatic test_clamp();
    repeat (30) @(negedge clk);
    write_cmd(5, 900);
    settle();
    check_frame("clamp_5_900");
    repeat (30) @(negedge clk);
    write_cmd(0, 900);
    wait_frame();
    check_frame("clamp_off");
  endtask

  function automatic int rand_cmd();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return int'($urandom_range(1, MIN_US - 1));
      2:       return int'($urandom_range(MIN_US, MAX_US));
      default: return int'($urandom_range(MAX_US + 1, (1 << W) - 1));
    endcase
  endfunction

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(5, 120)) @(negedge clk);
      write_cmd(rand_cmd(), rand_cmd());
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
        write_cmd(rand_cmd(), rand_cmd());
      end
      wait_frame();
      tests++;
      if (bus.update_pending !== m_upd) begin
        fails++;
        $display("FAIL random_pending it%0d: got %b expected %b", it, bus.update_pending, m_upd);
      end
      check_frame("random");
    end
  endtask

  task automatic test_back_to_back();
    repeat (40) @(negedge clk);
    write_cmd(20, 35);
    settle();
    repeat (FRAME_CLK - 1) @(negedge clk);
    write_cmd(40, 35);
    tests++;
    if (bus.frame_start !== 1'b1 || bus.update_pending !== 1'b1) begin
      fails++;
      $display("FAIL boundary_write: fs=%b upd=%b expected 1/1", bus.frame_start, bus.update_pending);
    end
    check_frame("boundary_old");
    tests++;
    if (bus.update_pending !== m_upd) begin
      fails++;
      $display("FAIL boundary_pending_after: got %b expected %b", bus.update_pending, m_upd);
    end
    check_frame("boundary_new");
  endtask

  task automatic test_enable();
    int hi0 = 0;
    int fs = 0;
    repeat (40) @(negedge clk);
    write_cmd(40, 0);
    settle();
    snapshot();
    for (int i = 0; i < FRAME_CLK; i++) begin
      if (bus.frame_start === 1'b1) fs++;
      if (bus.pwm[0] === 1'b1) hi0++;
      if (i == 20) bus.en = 1'b0;
      if (i == 21) begin
        tests++;
        if (bus.pwm[0] !== 1'b0) begin
          fails++;
          $display("FAIL en_low: pwm0=%b expected 0", bus.pwm[0]);
        end
      end
      if (i == 40) bus.en = 1'b1;
      if (i == 41) begin
        tests++;
        if (bus.pwm[0] !== 1'b1) begin
          fails++;
          $display("FAIL en_resume: pwm0=%b expected 1", bus.pwm[0]);
        end
      end
      @(negedge clk);
    end
    tests++;
    if (hi0 !== exp_hi[0] - 20) begin
      fails++;
      $display("FAIL en_high_clk: got %0d expected %0d", hi0, exp_hi[0] - 20);
    end
    tests++;
    if (fs !== 1 || bus.frame_start !== 1'b1) begin
      fails++;
      $display("FAIL en_frame_timing: pulses=%0d next_start=%b expected 1/1", fs, bus.frame_start);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.pwm, bus.frame_start, bus.update_pending} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: pwm=%b fs=%b upd=%b expected all 0",
               bus.pwm, bus.frame_start, bus.update_pending);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    while (bus.frame_start !== 1'b1 && n < 5 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != FRAME_CLK) begin
      fails++;
      $display("FAIL reset_mid_restart: frame_start at clk %0d expected %0d", n, FRAME_CLK);
    end
    check_frame("after_reset");
  endtask

`ifdef SERVO_SLEW_EN
  task automatic test_slew();
    repeat (30) @(negedge clk);
    write_cmd(20, 20);
    settle();
    repeat (30) @(negedge clk);
    write_cmd(40, 20);
    for (int k = 0; k < 4; k++) begin
      wait_frame();
      tests++;
      if (bus.update_pending !== (k < 3)) begin
        fails++;
        $display("FAIL slew_pending step%0d: got %b expected %b", k, bus.update_pending, (k < 3));
      end
      measure_frame();
      tests++;
      if (hi_cnt[0] !== int'(TPU) * (25 + 5 * k)) begin
        fails++;
        $display("FAIL slew_step%0d: got %0d expected %0d", k, hi_cnt[0], int'(TPU) * (25 + 5 * k));
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_clamp();
    test_random();
    test_back_to_back();
    test_enable();
    test_reset_mid();
`ifdef SERVO_SLEW_EN
    test_slew();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
